tick_gen_multi: RTL

- Parametrised multi-channel clock-enable generator on the clk_5MHz domain.
- Replaces derived-clock dividers with per-channel single-cycle tick enables and registered square outputs.
- Channels cover FSM step, debounce sample, LED blink and buzzer tone.
- Each channel has a runtime-programmable divisor with glitch-free deferred update, pause, and a global phase-align restart.

---
 rtl/tick_gen_pkg.sv | 18 +
 rtl/tick_gen_ch.sv | 72 +++++++
 rtl/tick_gen_multi.sv | 48 ++++
 3 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants for the multi-channel tick generator.
// Channel roles and 5 MHz divisors for the legacy timing users.
package tick_gen_pkg;

    localparam int DIV_W_DEF     = 17;
    localparam int RESET_DIV_DEF = 65535;

    localparam int CH_FSM      = 0;
    localparam int CH_DEBOUNCE = 1;
    localparam int CH_BLINK    = 2;
    localparam int CH_TONE     = 3;

    // tick period = d+1 cycles of 5 MHz
    localparam logic [DIV_W_DEF-1:0] DIV_FSM      = 17'd65535;
    localparam logic [DIV_W_DEF-1:0] DIV_DEBOUNCE = 17'd4999;
    localparam logic [DIV_W_DEF-1:0] DIV_TONE     = 17'd2499;

endpackage

// File: rtl/tick_gen_ch.sv
// One tick channel: down-counter, active/shadow divisor,
// registered tick pulse and square output.
module tick_gen_ch #(
    parameter int DIV_W     = 17,
    parameter int RESET_DIV = 65535
) (
    input  logic             clk_5MHz,
    input  logic             rst_n,
    input  logic             run,
    input  logic             sync,
    input  logic             we,
    input  logic [DIV_W-1:0] wdata,
    output logic             tick,
    output logic             sq,
    output logic             pending
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] reload;
    logic             tc;

    assign tc = run && (cnt == '0);

    // a write landing on a reload edge wins over any shadow
    always_comb begin
        reload = active;
        if (we)
            reload = wdata;
        else if (pending)
            reload = shadow;
    end

    always_ff @(posedge clk_5MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= RST_DIV;
            active  <= RST_DIV;
            shadow  <= '0;
            pending <= 1'b0;
            tick    <= 1'b0;
            sq      <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (sync) begin
                cnt     <= reload;
                active  <= reload;
                pending <= 1'b0;
                sq      <= 1'b0;
            end else if (tc) begin
                tick    <= 1'b1;
                sq      <= ~sq;
                cnt     <= reload;
                active  <= reload;
                pending <= 1'b0;
            end else if (run) begin
                cnt <= cnt - DIV_W'(1);
                if (we) begin
                    shadow  <= wdata;
                    pending <= 1'b1;
                end
            end else if (we) begin
                cnt     <= wdata;
                active  <= wdata;
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel clock-enable generator on clk_5MHz.
// Decodes divisor writes and fans controls out to each channel.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = DIV_W_DEF,
    parameter int RESET_DIV = RESET_DIV_DEF,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_5MHz,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              ch_sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] div_pending
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_we;
        logic ch_run;

        // equality with i < NUM_CH also rejects out-of-range indices
        assign ch_we  = cfg_we && (cfg_ch == CH_W'(i));
        assign ch_run = en && ch_en[i];

        tick_gen_ch #(
            .DIV_W    (DIV_W),
            .RESET_DIV(RESET_DIV)
        ) u_ch (
            .clk_5MHz(clk_5MHz),
            .rst_n   (rst_n),
            .run     (ch_run),
            .sync    (ch_sync),
            .we      (ch_we),
            .wdata   (cfg_div),
            .tick    (tick[i]),
            .sq      (sq[i]),
            .pending (div_pending[i])
        );
    end

endmodule
